// File: rtl/data_memory_ws.sv
// Word-organised data memory with big-endian byte lanes and a fixed,
// parameterised wait-state latency.
//
// Accesses follow an IDLE -> BUSY -> RESP handshake. A request is captured
// in IDLE, waits out WAIT_STATES cycles in BUSY, and then the array access
// happens on the edge that enters RESP. Ready pulses for exactly that one
// RESP cycle. A misaligned access leaves the array untouched, raises
// AddrError during RESP, and returns zero for a load.
module data_memory_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  Stall,
    output logic                  AddrError
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [3:0]            waitCount;

    logic [ADDR_WIDTH+1:0] addrQ;
    logic [DATA_WIDTH-1:0] dataQ;
    logic [1:0]            sizeQ;
    logic                  unsignedQ;
    logic                  readQ;
    logic                  writeQ;

    logic [DATA_WIDTH-1:0] memArray [DEPTH];

    logic                  request;
    logic                  accept;
    logic                  enterResp;
    logic [ADDR_WIDTH+1:0] accAddr;
    logic [DATA_WIDTH-1:0] accData;
    logic [1:0]            accSize;
    logic                  accUnsigned;
    logic                  accRead;
    logic                  accWrite;
    logic [ADDR_WIDTH-1:0] accIndex;
    logic [1:0]            accOffset;
    logic                  misaligned;
    logic [3:0]            laneEnable;
    logic [DATA_WIDTH-1:0] laneData;
    logic [DATA_WIDTH-1:0] memWord;
    logic [7:0]            selByte;
    logic [15:0]           selHalf;
    logic [DATA_WIDTH-1:0] loadValue;
    logic                  unusedAddrBits;

    // Address bits above the array index wrap around and are deliberately ignored.
    assign unusedAddrBits = ^Address[31:ADDR_WIDTH+2];

    assign request   = MemRead | MemWrite;
    assign accept    = (state == IDLE) && request;
    assign enterResp = (accept && (WAIT_STATES == 0)) ||
                       ((state == BUSY) && (waitCount == 4'd1));
    assign Ready     = (state == RESP);
    assign Stall     = request & ~Ready;

    // With zero wait states the access happens on the request edge itself, so
    // it must use the live inputs; otherwise it uses the values captured in IDLE.
    always_comb begin
        accAddr     = addrQ;
        accData     = dataQ;
        accSize     = sizeQ;
        accUnsigned = unsignedQ;
        accRead     = readQ;
        accWrite    = writeQ;
        if (state == IDLE) begin
            accAddr     = Address[ADDR_WIDTH+1:0];
            accData     = WriteData;
            accSize     = Size;
            accUnsigned = Unsigned;
            accRead     = MemRead;
            accWrite    = MemWrite;
        end
    end

    assign accIndex   = accAddr[ADDR_WIDTH+1:2];
    assign accOffset  = accAddr[1:0];
    assign misaligned = ((accSize == 2'b01) && accOffset[0]) ||
                        (accSize[1] && (accOffset != 2'b00));

    // Store lane mask and replicated store data; lane 3 is the big-endian byte 0.
    always_comb begin
        laneEnable = 4'b1111;
        laneData   = accData;
        case (accSize)
            2'b00: begin
                laneEnable = 4'b1000 >> accOffset;
                laneData   = {4{accData[7:0]}};
            end
            2'b01: begin
                laneEnable = accOffset[1] ? 4'b0011 : 4'b1100;
                laneData   = {2{accData[15:0]}};
            end
            default: begin
                laneEnable = 4'b1111;
                laneData   = accData;
            end
        endcase
    end

    // Load path: pick the addressed lanes and sign- or zero-extend them.
    always_comb begin
        memWord = memArray[accIndex];
        selByte = memWord[31:24];
        selHalf = accOffset[1] ? memWord[15:0] : memWord[31:16];
        case (accOffset)
            2'b00:   selByte = memWord[31:24];
            2'b01:   selByte = memWord[23:16];
            2'b10:   selByte = memWord[15:8];
            default: selByte = memWord[7:0];
        endcase
        case (accSize)
            2'b00:   loadValue = {{(DATA_WIDTH-8){~accUnsigned & selByte[7]}}, selByte};
            2'b01:   loadValue = {{(DATA_WIDTH-16){~accUnsigned & selHalf[15]}}, selHalf};
            default: loadValue = memWord;
        endcase
    end

    // Next-state logic; RESP always falls back to IDLE so a held request is not re-run.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (request) nextState = (WAIT_STATES == 0) ? RESP : BUSY;
            BUSY: if (waitCount == 4'd1) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // Wait-state counter: loaded on acceptance, counted down while BUSY.
    always_ff @(posedge Clk) begin
        if (Reset)              waitCount <= 4'd0;
        else if (accept)        waitCount <= WAIT_INIT;
        else if (state == BUSY) waitCount <= waitCount - 4'd1;
    end

    // Capture the request so the core's bus may change during the wait states.
    always_ff @(posedge Clk) begin
        if (!Reset && accept) begin
            addrQ     <= Address[ADDR_WIDTH+1:0];
            dataQ     <= WriteData;
            sizeQ     <= Size;
            unsignedQ <= Unsigned;
            readQ     <= MemRead;
            writeQ    <= MemWrite;
        end
    end

    // Lane-masked array write; reset blocks a store completing on the same edge.
    always_ff @(posedge Clk) begin
        if (!Reset && enterResp && accWrite && !misaligned) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (laneEnable[lane]) memArray[accIndex][8*lane +: 8] <= laneData[8*lane +: 8];
            end
        end
    end

    // Load result and error flag; a combined read+write counts as a store only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ReadData  <= '0;
            AddrError <= 1'b0;
        end else begin
            AddrError <= enterResp & misaligned;
            if (enterResp && accRead && !accWrite) begin
                ReadData <= misaligned ? '0 : loadValue;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: a directed vector table, reset and
// zero-wait-state sequences, then random accesses against a word-array model.
module tb_data_memory_ws;

    logic        Clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [1:0]  size;
    logic        isUnsigned;

    logic        memRead, memWrite;
    logic [31:0] readData;
    logic        ready, stall, addrError;

    logic        memRead0, memWrite0;
    logic [31:0] readData0;
    logic        ready0, stall0, addrError0;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelMem [1024];
    logic [31:0] modelRd;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] expData;
        bit          expErr;
    } vecT;

    vecT vecs[$];

    data_memory_ws dut (
        .Clk(Clk), .Reset(reset), .Address(address), .WriteData(writeData),
        .MemRead(memRead), .MemWrite(memWrite), .Size(size), .Unsigned(isUnsigned),
        .ReadData(readData), .Ready(ready), .Stall(stall), .AddrError(addrError)
    );

    data_memory_ws #(.WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(reset), .Address(address), .WriteData(writeData),
        .MemRead(memRead0), .MemWrite(memWrite0), .Size(size), .Unsigned(isUnsigned),
        .ReadData(readData0), .Ready(ready0), .Stall(stall0), .AddrError(addrError0)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic bit isMisaligned(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b01) return (a % 2) != 0;
        if (s >= 2'b10) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] s, input bit u);
        logic [31:0] w;
        logic [31:0] v;
        int off;
        w   = modelMem[(a / 4) % 1024];
        off = int'(a % 4);
        if (s == 2'b00) begin
            v = (w >> (8 * (3 - off))) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFFFF00;
        end else if (s == 2'b01) begin
            v = (w >> (16 * (1 - off / 2))) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic modelStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        logic [31:0] w;
        logic [31:0] mask;
        int off;
        int sh;
        w   = modelMem[(a / 4) % 1024];
        off = int'(a % 4);
        if (s == 2'b00) begin
            sh   = 8 * (3 - off);
            mask = 32'hFF << sh;
            w    = (w & ~mask) | ((d & 32'hFF) << sh);
        end else if (s == 2'b01) begin
            sh   = 16 * (1 - off / 2);
            mask = 32'hFFFF << sh;
            w    = (w & ~mask) | ((d & 32'hFFFF) << sh);
        end else begin
            w = d;
        end
        modelMem[(a / 4) % 1024] = w;
    endtask

    // Runs one full handshake on the selected instance; entered and left just after a rising edge.
    task automatic applyStimulus(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                                 output logic [31:0] rdata, output bit err, output int latency,
                                 output int stallCycles, output bit readyOnce, output bit errLeak);
        bit seen;
        address    = addr;
        writeData  = wd;
        size       = sz;
        isUnsigned = uns;
        if (sel) begin memRead0 = rd; memWrite0 = wr; end
        else     begin memRead  = rd; memWrite  = wr; end
        latency = -1; stallCycles = 0; errLeak = 1'b0; seen = 1'b0;
        rdata = 32'hX; err = 1'b0;
        #1;
        if (sel ? stall0 : stall) stallCycles++;
        for (int n = 1; n <= 24 && !seen; n++) begin
            @(posedge Clk); #1;
            if (sel ? ready0 : ready) begin
                seen    = 1'b1;
                latency = n;
                rdata   = sel ? readData0 : readData;
                err     = sel ? addrError0 : addrError;
            end else begin
                if (sel ? stall0 : stall) stallCycles++;
                if (sel ? addrError0 : addrError) errLeak = 1'b1;
            end
        end
        memRead = 1'b0; memWrite = 1'b0; memRead0 = 1'b0; memWrite0 = 1'b0;
        @(posedge Clk); #1;
        readyOnce = !(sel ? ready0 : ready);
        if (sel ? addrError0 : addrError) errLeak = 1'b1;
    endtask

    task automatic runModelOp(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] sz, input bit uns);
        logic [31:0] got;
        bit err, once, leak, expErr;
        int lat, stl;
        expErr = isMisaligned(addr, sz);
        if (wr) begin
            if (!expErr) modelStore(addr, wd, sz);
        end else begin
            modelRd = expErr ? 32'h0 : modelLoad(addr, sz, uns);
        end
        applyStimulus(1'b0, rd, wr, addr, wd, sz, uns, got, err, lat, stl, once, leak);
        checkOutput($sformatf("rand@%h.data", addr), got, modelRd);
        checkOutput($sformatf("rand@%h.err", addr), 32'(err), 32'(expErr));
        checkOutput($sformatf("rand@%h.latency", addr), 32'(lat), 32'd3);
    endtask

    initial begin
        logic [31:0] got;
        bit err, once, leak;
        int lat, stl, pulses, firstAt;

        reset = 1'b1; address = '0; writeData = '0; size = 2'b10; isUnsigned = 1'b0;
        memRead = 1'b0; memWrite = 1'b0; memRead0 = 1'b0; memWrite0 = 1'b0;
        repeat (3) @(posedge Clk);
        #1 reset = 1'b0;

        checkOutput("reset.readData", readData, 32'h0);
        checkOutput("reset.ready", 32'(ready), 32'h0);
        checkOutput("reset.addrError", 32'(addrError), 32'h0);
        checkOutput("reset.stall", 32'(stall), 32'h0);

        // Directed vectors: {rd, wr, addr, wdata, size, uns, ReadData during RESP, AddrError}
        vecs.push_back('{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h11, 32'h000000AA, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h11AA3344, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'hFFFFFFAA, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h000000AA, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 32'h8000FFFF, 2'b10, 1'b0, 32'h000000AA, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h13, 32'h0,        2'b01, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h8000FFFF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h11, 32'h00001234, 2'b01, 1'b0, 32'h8000FFFF, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h8000FFFF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h00008000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'h0,        2'b01, 1'b0, 32'hFFFF8000, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 2'b10, 1'b0, 32'hFFFF8000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h14, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h16, 32'h0,        2'b10, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h14, 32'h0,        2'b11, 1'b0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h17, 32'h0,        2'b00, 1'b1, 32'h0000000D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h14, 32'h0,        2'b00, 1'b0, 32'hFFFFFFCA, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h15, 32'h00000000, 2'b10, 1'b0, 32'hFFFFFFCA, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h14, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                          vecs[i].uns, got, err, lat, stl, once, leak);
            checkOutput($sformatf("vec%0d.data", i), got, vecs[i].expData);
            checkOutput($sformatf("vec%0d.addrError", i), 32'(err), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'd3);
            checkOutput($sformatf("vec%0d.stallCycles", i), 32'(stl), 32'd3);
            checkOutput($sformatf("vec%0d.readyOnce", i), 32'(once), 32'd1);
            checkOutput($sformatf("vec%0d.errOutsideResp", i), 32'(leak), 32'd0);
        end

        // Reset while a store is in BUSY: no Ready, no write, ReadData cleared.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 2'b10, 1'b0, got, err, lat, stl, once, leak);
        address = 32'h20; writeData = 32'h55555555; size = 2'b10; memWrite = 1'b1;
        pulses = 0;
        @(posedge Clk); #1;
        if (ready) pulses++;
        reset = 1'b1;
        @(posedge Clk); #1;
        if (ready) pulses++;
        checkOutput("abort.readDataCleared", readData, 32'h0);
        reset = 1'b0; memWrite = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge Clk); #1;
            if (ready) pulses++;
        end
        checkOutput("abort.readyPulses", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, got, err, lat, stl, once, leak);
        checkOutput("abort.loadBack", got, 32'h0);
        checkOutput("abort.loadLatency", 32'(lat), 32'd3);

        // Zero wait states: held request completes once; 0x1010 aliases word 4.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, got, err, lat, stl, once, leak);
        checkOutput("ws0.storeLatency", 32'(lat), 32'd1);
        checkOutput("ws0.stallCycles", 32'(stl), 32'd1);
        address = 32'h1010; writeData = 32'h11111111; size = 2'b10; memWrite0 = 1'b1;
        pulses = 0; firstAt = 0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge Clk); #1;
            if (ready0) begin
                pulses++;
                if (firstAt == 0) firstAt = n;
            end
            if (n == 2) memWrite0 = 1'b0;
        end
        checkOutput("ws0.heldPulses", 32'(pulses), 32'd1);
        checkOutput("ws0.heldFirstReady", 32'(firstAt), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, got, err, lat, stl, once, leak);
        checkOutput("ws0.aliasLoad", got, 32'h11111111);
        checkOutput("ws0.loadLatency", 32'(lat), 32'd1);
        checkOutput("ws0.readyOnce", 32'(once), 32'd1);

        // Random traffic over words 0..15 with random ignored upper address bits.
        modelRd = 32'h0;
        for (int w = 0; w < 16; w++) begin
            runModelOp(1'b0, 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0);
        end
        for (int n = 0; n < 80; n++) begin
            bit rd, wr;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            runModelOp(rd, wr, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data word width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the log2 of depth in words.
REQ-003 SHALL have parameter WAIT_STATES, default 2, the extra access latency in cycles; legal range 0..15.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port Address, input, 32 bits: the byte address from the core.
REQ-007 SHALL have port WriteData, input, 32 bits: store data, right-aligned for byte and halfword stores.
REQ-008 SHALL have port MemRead, input, 1 bit: load request, held by the core until Ready.
REQ-009 SHALL have port MemWrite, input, 1 bit: store request, held by the core until Ready.
REQ-010 SHALL have port Size, input, 2 bits: access size; 00 = byte, 01 = halfword, 10 = word, 11 = word.
REQ-011 SHALL have port Unsigned, input, 1 bit: 1 zero-extends sub-word loads; 0 sign-extends them.
REQ-012 SHALL have port ReadData, output, 32 bits: load result, extended and right-aligned.
REQ-013 SHALL have port Ready, output, 1 bit: a one-cycle access-complete pulse.
REQ-014 SHALL have port Stall, output, 1 bit: the core-freeze request.
REQ-015 SHALL have port AddrError, output, 1 bit: misaligned-access flag, valid while Ready=1.

Function
REQ-016 SHALL store 2^ADDR_WIDTH words, indexed by Address[ADDR_WIDTH+1:2]; upper address bits ignored (aliasing/wrap).
REQ-017 SHALL use big-endian byte lanes: offset 00 = bits 31:24, offset 11 = bits 7:0; halfword offset 00 = bits 31:16.
REQ-018 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE: request (MemRead|MemWrite) sampled at edge k.
- On that edge: latch Address, WriteData, Size, Unsigned and op; load counter with WAIT_STATES.
- Transition to BUSY, or directly to RESP when WAIT_STATES=0.
REQ-019 SHALL decrement the counter each edge in BUSY and enter RESP on the edge where the counter equals 1.
REQ-020 SHALL perform the array access on the edge entering RESP.
- Store: byte-lane-masked write; only the addressed lanes change.
- Load: ReadData registered from the addressed lanes, then extended.
REQ-021 SHALL assert Ready only in RESP, exactly one cycle, WAIT_STATES+1 cycles after the request edge.
REQ-022 SHALL ignore request inputs in RESP and return to IDLE unconditionally, so a held request is not re-issued.
- A new request is accepted from the following IDLE cycle; back-to-back accesses are spaced WAIT_STATES+2 cycles apart.
REQ-023 SHALL drive Stall = (MemRead|MemWrite) & ~Ready combinationally.
REQ-024 SHALL hold ReadData from RESP until the next load completes; stores and errors do not alter it, except per REQ-026.
REQ-025 SHALL treat MemRead=1 and MemWrite=1 together as a store only; ReadData is unchanged.
REQ-026 SHALL flag misalignment: halfword with Address[0]=1, or word with Address[1:0]!=00.
- Array left unmodified.
- Ready still follows normal latency, with AddrError=1 in RESP.
- Load ReadData = 0.
REQ-027 SHALL drive AddrError=0 in every cycle outside RESP.

Reset
REQ-028 SHALL, when Reset=1 at an edge, enter IDLE, clear the counter, and set ReadData=0, Ready=0, AddrError=0.
REQ-029 SHALL give Reset priority over any access; a store pending on the same edge is not committed.
REQ-030 SHALL NOT clear array contents on reset.
REQ-031 SHALL require a request aborted by Reset to be re-presented; it is sampled again at the first edge after Reset falls.

Verification
REQ-032 Word store 0xDEADBEEF @0x10, then word load @0x10, WAIT_STATES=2 -> Ready 3 cycles after each request edge; ReadData=0xDEADBEEF; Stall high 3 cycles per access.
REQ-033 Byte store 0x000000AA @0x11 over 0x11223344, then word load -> 0x11AA3344; lb @0x11 signed -> 0xFFFFFFAA; lbu -> 0x000000AA.
REQ-034 Halfword load @0x12 on 0x8000FFFF, Unsigned=0 -> 0xFFFFFFFF; half load @0x13 -> AddrError=1 in RESP, ReadData=0, array unchanged.
REQ-035 Reset asserted in BUSY during word store 0x55555555 @0x20 (prior 0x0) -> Ready never pulses, subsequent load @0x20 returns 0x00000000.
REQ-036 WAIT_STATES=0: request held 2 cycles -> Ready on cycle 1 only, one array write; address 0x1010 with ADDR_WIDTH=10 aliases word 0x004.
